conv1_psum_collector: RTL and testbench
=======================================

// Module: conv1_psum_collector
// PURPOSE
// - Receiver end of the conv1 PE-column psum interface: consumes the 20-bit signed Psum_out stream of one PE column.
// - Accumulates C_IN per-channel psums into one output pixel, adds bias, applies optional ReLU, round-shift and saturation to OUT_W.
// - Buffers results in a small FIFO towards the feature-map writer using a valid/ready handshake.
// PARAMETERS
// - PSUM_W     20  width of signed psum from PE column
// - ACC_W      24  signed accumulator / bias width
// - C_IN       3   psums accumulated per output pixel (>=1)
// - OUT_W      8   signed output width
// - FIFO_DEPTH 4   output FIFO entries (power of 2)
// PORTS
// - clk          in   1                       PE clock
// - rst_n        in   1                       async reset, active low
// - en           in   1                       enable, same signal as PE column en
// - clr          in   1                       sync clear: channel count, pipeline, FIFO, overflow
// - psum_valid   in   1                       psum_in valid this cycle (from controller delay line)
// - psum_in      in   PSUM_W                  signed psum from PE column
// - bias         in   ACC_W                   signed bias, sampled with channel-0 psum
// - shift        in   4                       arithmetic right-shift amount
// - relu_en      in   1                       1: clamp negative sums to 0 before shift
// - out_valid    out  1                       FIFO head valid
// - out_ready    in   1                       downstream accepts head
// - out_data     out  OUT_W                  signed result at FIFO head
// - fifo_count   out  $clog2(FIFO_DEPTH)+1    occupied entries
// - busy         out  1                       channel count != 0 (pixel partially accumulated)
// - overflow     out  1                       sticky: result dropped, FIFO full
// BEHAVIOUR
// - Reset: acc=0, ch_cnt=0, post-stage valid=0, FIFO empty; out_valid=0, out_data=0, fifo_count=0, busy=0, overflow=0.
// - clr (sync, priority over all except reset): same state as reset in next cycle; psum in same cycle discarded.
// - en=0: accumulator, ch_cnt, post stage frozen, psum_valid ignored; FIFO pop (out_valid&out_ready) still active.
// - Accumulate (en&psum_valid): ch_cnt==0 -> acc<=bias+sext(psum_in); else acc<=acc+sext(psum_in); adds saturate to ACC_W.
// - ch_cnt increments; at ch_cnt==C_IN-1 wraps to 0 and final sum (acc+psum, or bias+psum when C_IN=1) is loaded into post stage.
// - Post stage (1 reg): s=relu_en&&sum<0 ? 0 : sum; shift>0: r=(s+(1<<(shift-1)))>>>shift (round half up), else r=s;
//   saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; push to FIFO next cycle.
// - Latency: last-channel psum_valid at cycle N -> out_valid=1 at N+2 when FIFO was empty.
// - FIFO push accepted if count<FIFO_DEPTH, or count==FIFO_DEPTH with pop in same cycle; otherwise result dropped, overflow<=1.
// - Simultaneous push and pop: count unchanged, order preserved; pop on empty ignored.
// - out_data holds head value while out_valid&!out_ready; out_data=0 when empty.
// - Reset/clr mid-pixel: partial sum discarded, next psum treated as channel 0.
// STRUCTURE
// - Shared package conv1_pkg: PSUM_W, ACC_W, OUT_W constants, saturating-add and saturate-to-width functions.
// - One sub-module: conv1_psum_fifo (sync FIFO, push/pop/full/empty/count, clr).
// - Top: channel counter FSM (ACCUM count 0..C_IN-1), accumulator, post-process register.
// TESTING
// - C_IN=3, bias=0, shift=3, relu off; psums 100,200,300 -> out_data=75 at N+2 ((600+4)>>>3).
// - psums -50,-60,-70, shift=0: relu off -> -128 (sat); relu on -> 0.
// - psums 4,4,4, bias=0, shift=3 -> 2 ((12+4)>>>3); bias=-12 same psums -> 0.
// - out_ready=0, push 5 pixels -> fifo_count=4, overflow=1, drain yields first 4 in order.
// - Full FIFO with out_ready=1 in same cycle as push -> no drop, count stays 4, overflow stays 0.
// - rst_n low after 2 channels, then 3 psums of 8, shift=0 -> single result 24, busy 0 after third.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared widths, types and saturation helpers for the conv1 psum datapath.
// Pure combinational functions; no latency or flow control of their own.
package conv1_pkg;

  localparam int PSUM_W = 20;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [ACC_W:0]    ext_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } ch_state_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam ext_t OUT_MAX = ext_t'((2**(OUT_W-1)) - 1);
  localparam ext_t OUT_MIN = ext_t'(-(2**(OUT_W-1)));

  function automatic acc_t sat_add(input acc_t a, input acc_t b);
    ext_t s;
    s = ext_t'(a) + ext_t'(b);
    if (s > ext_t'(ACC_MAX)) return ACC_MAX;
    if (s < ext_t'(ACC_MIN)) return ACC_MIN;
    return s[ACC_W-1:0];
  endfunction

  function automatic out_t sat_out(input ext_t x);
    if (x > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (x < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv1_psum_fifo.sv
// Small synchronous FIFO for finished output pixels; head is visible combinationally.
// Push into a full FIFO succeeds only with a same-cycle pop, otherwise it is reported as dropped.
module conv1_psum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/conv1_psum_collector.sv
// Sums C_IN channel psums plus bias per pixel, then ReLU/round-shift/saturate into an output FIFO.
// Last psum to out_valid is 2 cycles on an empty FIFO; results arriving at a full, unpopped FIFO are dropped.
module conv1_psum_collector
  import conv1_pkg::*;
#(
  parameter int C_IN       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          psum_valid,
  input  logic signed [PSUM_W-1:0]      psum_in,
  input  logic signed [ACC_W-1:0]       bias,
  input  logic [3:0]                    shift,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int CNT_W = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(C_IN - 1);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] ch_cnt, ch_cnt_nxt;
  logic             take, first, last;
  acc_t             acc, sum_cur;
  logic             post_vld;
  out_t             post_dat;
  logic             push, drop, fifo_full, fifo_empty;

  function automatic out_t post_proc(input acc_t sum, input logic [3:0] sh, input logic relu);
    ext_t s;
    ext_t rnd;
    if (relu && sum < 0) s = '0;
    else                 s = ext_t'(sum);
    if (sh != 4'd0) begin
      rnd = '0;
      rnd[sh - 4'd1] = 1'b1;
      s = (s + rnd) >>> sh;
    end
    return sat_out(s);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ch_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ch_cnt <= ch_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_cnt_nxt = ch_cnt;
    if (clr) begin
      state_nxt  = ST_IDLE;
      ch_cnt_nxt = '0;
    end else if (take) begin
      if (last) begin
        state_nxt  = ST_IDLE;
        ch_cnt_nxt = '0;
      end else begin
        state_nxt  = ST_ACCUM;
        ch_cnt_nxt = ch_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    take  = en & psum_valid;
    first = (state == ST_IDLE);
    last  = (ch_cnt == LAST_CH);
    busy  = (state == ST_ACCUM);
  end

  // Channel 0 restarts from bias, so a stale acc never leaks into a new pixel.
  assign sum_cur = sat_add(first ? bias : acc, acc_t'(psum_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      post_vld <= 1'b0;
      post_dat <= '0;
    end else if (clr) begin
      acc      <= '0;
      post_vld <= 1'b0;
      post_dat <= '0;
    end else if (take) begin
      acc      <= sum_cur;
      post_vld <= last;
      if (last) post_dat <= post_proc(sum_cur, shift, relu_en);
    end else if (en) begin
      post_vld <= 1'b0;
    end
  end

  assign push = en & post_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow <= 1'b0;
    else if (clr)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  conv1_psum_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .push_dat (post_dat),
    .pop      (out_ready),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .drop     (drop)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_conv1_psum_collector.sv
// Directed bench for conv1_psum_collector with hand-computed expected pixels.
module tb_conv1_psum_collector;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clr;
  logic               psum_valid;
  logic signed [19:0] psum_in;
  logic signed [23:0] bias;
  logic [3:0]         shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic [2:0]         fifo_count;
  logic               busy;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  conv1_psum_collector #(.C_IN(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .bias       (bias),
    .shift      (shift),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_pixel(input int p0, input int p1, input int p2);
    psum_valid = 1'b1;
    psum_in = 20'(p0); tick();
    psum_in = 20'(p1); tick();
    psum_in = 20'(p2); tick();
    psum_valid = 1'b0;
    psum_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; psum_valid = 1'b0; psum_in = '0;
    bias = '0; shift = 4'd3; relu_en = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // 100+200+300 = 600, (600+4)>>>3 = 75
    psum_valid = 1'b1;
    psum_in = 20'sd100; tick();
    psum_in = 20'sd200; tick();
    check("busy_mid_pixel", busy, 1);
    psum_in = 20'sd300; tick();
    psum_valid = 1'b0;
    check("lat_n1_not_valid", out_valid, 0);
    check("busy_after_last", busy, 0);
    tick();
    check("lat_n2_valid", out_valid, 1);
    check("pix1_data", out_data, 75);
    check("pix1_count", fifo_count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pop_empty_valid", out_valid, 0);
    check("pop_empty_data", out_data, 0);

    // -180 saturates to -128, or clamps to 0 with ReLU
    shift = 4'd0;
    send_pixel(-50, -60, -70); tick();
    check("neg_sat", out_data, -128);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    relu_en = 1'b1;
    send_pixel(-50, -60, -70); tick();
    check("relu_zero", out_data, 0);
    check("relu_valid", out_valid, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    relu_en = 1'b0;

    // (12+4)>>>3 = 2; with bias -12, (0+4)>>>3 = 0
    shift = 4'd3;
    send_pixel(4, 4, 4); tick();
    check("round_small", out_data, 2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    bias = -24'sd12;
    send_pixel(4, 4, 4); tick();
    check("bias_neg", out_data, 0);
    check("bias_neg_valid", out_valid, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    bias = '0;

    // en low freezes accumulation and ignores psum_valid: 10+20+30 = 60
    shift = 4'd0;
    psum_valid = 1'b1;
    psum_in = 20'sd10; tick();
    psum_in = 20'sd20; tick();
    en = 1'b0;
    psum_in = 20'sd999; tick(); tick();
    check("en_low_busy_held", busy, 1);
    en = 1'b1;
    psum_in = 20'sd30; tick();
    psum_valid = 1'b0; tick();
    check("en_freeze_sum", out_data, 60);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // five pixels into a stalled FIFO: the fifth is dropped
    for (int k = 1; k <= 5; k++) send_pixel(k, 0, 0);
    tick();
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head_hold", out_data, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_drain_%0d", k), out_data, k);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check("ovf_drained", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_overflow", overflow, 0);

    // push into a full FIFO while popping: nothing lost
    for (int k = 11; k <= 14; k++) send_pixel(k, 0, 0);
    tick();
    check("full_count", fifo_count, 4);
    send_pixel(15, 0, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("full_pp_count", fifo_count, 4);
    check("full_pp_overflow", overflow, 0);
    for (int k = 12; k <= 15; k++) begin
      check($sformatf("full_pp_drain_%0d", k), out_data, k);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check("full_pp_empty", out_valid, 0);

    // async reset mid-pixel discards the partial sum
    psum_valid = 1'b1;
    psum_in = 20'sd8; tick(); tick();
    psum_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0; #2;
    check("async_rst_busy", busy, 0);
    rst_n = 1'b1; #2;
    send_pixel(8, 8, 8);
    check("post_rst_busy", busy, 0);
    tick();
    check("post_rst_data", out_data, 24);
    check("post_rst_count", fifo_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
